param_shift_sequencer: RTL
==========================

Name: param_shift_sequencer

Overview:
Parametrised successor to the team's single-step shift register used in the Booth multiplier datapath. Adds generic width, four shift modes, a serial-out bit and an internal step sequencer. The sequencer performs N single-bit shifts on one start pulse and then signals done. The Booth controller uses it both for per-step arithmetic right shifts and for multi-bit alignment of operands.

Parameters:
WIDTH, 32, register width in bits (>=2)
CNT_W, 6, width of shift_amt and internal step counter; must hold WIDTH (CNT_W >= clog2(WIDTH+1))

Ports:
clk  input  1  clock, all state updates on rising edge
clr  input  1  synchronous active-high reset/clear
ld  input  1  parallel load of data_in
data_in  input  WIDTH  signed parallel load value
shift_en  input  1  single manual shift step (idle only)
start  input  1  launch sequenced shift of shift_amt steps
shift_amt  input  CNT_W  number of steps for sequenced shift
mode  input  2  00 logical right (s_in fills MSB), 01 arithmetic right (MSB replicated), 10 logical left (s_in fills LSB), 11 rotate right
s_in  input  1  serial fill bit for modes 00/10
data_out  output  WIDTH  signed register contents
s_out  output  1  registered bit shifted out by most recent step
busy  output  1  sequencer running
done  output  1  one-cycle pulse on sequence completion

Behaviour:
- Reset: clr high at an edge -> data_out=0, s_out=0, busy=0, done=0, counter=0, state IDLE. Overrides everything, including mid-sequence.
- Priority at each edge: clr > ld > sequencer step (RUN) > start (IDLE) > shift_en (IDLE).
- States: IDLE and RUN.
- IDLE + start, amt=min(shift_amt,WIDTH) > 0:
  - Latch mode and amt.
  - Go to RUN, busy=1.
  - No shift on the start edge.
- IDLE + start, effective amt=0:
  - Stay IDLE, done=1 for the next cycle.
  - data_out and s_out unchanged.
- RUN, each edge:
  - One step in the latched mode; counter decrements.
  - Step at counter==1: go to IDLE, busy=0, done=1 for exactly one cycle.
  - A sequence of N steps: busy high N cycles after the start edge; final data_out and done both visible after the Nth edge following the start edge.
- Single step per mode:
  - Mode 00: {s_in, d[W-1:1]}, s_out=d[0]
  - Mode 01: {d[W-1], d[W-1:1]}, s_out=d[0]
  - Mode 10: {d[W-2:0], s_in}, s_out=d[W-1]
  - Mode 11: {d[0], d[W-1:1]}, s_out=d[0]
- s_in is sampled live at each step edge, not latched at start.
- Mode, shift_en, start changes while busy: mode/shift_amt changes ignored (latched values used); start and shift_en ignored, no queuing.
- ld in IDLE: data_out=data_in, s_out unchanged, done=0.
- ld while busy: load wins, sequence aborted, state IDLE, busy=0, no done pulse.
- shift_en in IDLE (no start/ld): one step in the current (unlatched) mode. No done pulse, busy stays 0.
- start and shift_en together in IDLE: start wins, no manual step.
- done is 0 in every cycle except the single completion cycle; done and busy are never high together.
- shift_amt > WIDTH clamps to WIDTH. Counter never wraps.

Test Plan:
- Reset mid-sequence: WIDTH=32, load 0xF000_0000, start amt=10 mode 01, assert clr on 3rd RUN cycle -> next cycle data_out=0, busy=0, done=0, s_out=0.
- Arithmetic sequence: load 0x8000_0010, start amt=4 mode 01 -> busy high 4 cycles; then data_out=0xF800_0001, s_out=0, done high exactly 1 cycle.
- Left fill and rotate:
  - Load 0x0000_0001, start amt=3 mode 10 with s_in=1 -> data_out=0x0000_000F.
  - Then start amt=1 mode 11 -> data_out=0x8000_0007, s_out=1.
- Boundaries:
  - Start amt=0 -> done pulse next cycle, busy never high, data unchanged.
  - Start amt=40 (clamped to 32) mode 00 s_in=0 on 0xFFFF_FFFF -> 32 busy cycles, data_out=0, s_out=1.
- Abort and ignore:
  - During RUN, assert ld with 0x1234_5678 -> data_out=0x1234_5678, busy=0, no done.
  - During RUN, pulse start/shift_en and toggle mode -> final result matches latched mode only.
- Manual step: IDLE, shift_en=1 mode 00 s_in=1 on 0x0000_0002 -> data_out=0x8000_0001, s_out=0, done=0.

Source files
------------

// File: rtl/param_shift_sequencer.sv
// -----------------------------------------------------------------------------
// param_shift_sequencer
//
// Purpose:
//   Parametrised shift register with four shift modes, a serial-out bit and a
//   built-in step sequencer. A single start pulse runs N one-bit shifts,
//   one shift per clock, and then raises done for one cycle. The Booth
//   controller uses it for per-step arithmetic right shifts and for multi-bit
//   operand alignment.
//
// Parameters:
//   WIDTH : register width in bits (>= 2)
//   CNT_W : width of shift_amt and of the step counter; must be able to hold
//           the value WIDTH
//
// Ports:
//   clk       in   1      rising-edge clock
//   clr       in   1      synchronous active-high clear, overrides everything
//   ld        in   1      parallel load of data_in; aborts a running sequence
//   data_in   in   WIDTH  signed parallel load value
//   shift_en  in   1      single manual step in the live mode (idle only)
//   start     in   1      launch a sequenced shift of shift_amt steps
//   shift_amt in   CNT_W  step count; values above WIDTH are clamped
//   mode      in   2      00 lsr (s_in->MSB), 01 asr, 10 lsl (s_in->LSB),
//                         11 rotate right
//   s_in      in   1      serial fill bit, sampled live on each step edge
//   data_out  out  WIDTH  signed register contents
//   s_out     out  1      bit shifted out by the most recent step
//   busy      out  1      sequence running
//   done      out  1      one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module param_shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    ld,
   input  logic signed [WIDTH-1:0] data_in,
   input  logic                    shift_en,
   input  logic                    start,
   input  logic [CNT_W-1:0]        shift_amt,
   input  logic [1:0]              mode,
   input  logic                    s_in,
   output logic signed [WIDTH-1:0] data_out,
   output logic                    s_out,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                  r_state, w_state_next;
   logic signed [WIDTH-1:0] r_data,  w_data_next;
   logic                    r_sout,  w_sout_next;
   logic                    r_done,  w_done_next;
   logic [CNT_W-1:0]        r_cnt,   w_cnt_next;
   logic [1:0]              r_mode,  w_mode_next;

   logic [CNT_W-1:0]        w_amt;
   logic [WIDTH:0]          w_step_run;    // {s_out, data} for the latched mode
   logic [WIDTH:0]          w_step_man;    // {s_out, data} for the live mode

   // One-bit shift of d in mode m; result is {bit shifted out, new data}.
   function automatic logic [WIDTH:0] step_f(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       m,
      input logic             si
   );
      logic [WIDTH:0] res;
      case (m)
         2'b00:   res = {d[0],       si,         d[WIDTH-1:1]};
         2'b01:   res = {d[0],       d[WIDTH-1], d[WIDTH-1:1]};
         2'b10:   res = {d[WIDTH-1], d[WIDTH-2:0], si};
         default: res = {d[0],       d[0],       d[WIDTH-1:1]};
      endcase
      return res;
   endfunction

   // A request longer than the register is equivalent to WIDTH steps.
   assign w_amt = (shift_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_amt;

   assign w_step_run = step_f(r_data, r_mode, s_in);
   assign w_step_man = step_f(r_data, mode,   s_in);

   always_comb begin
      w_state_next = r_state;
      w_data_next  = r_data;
      w_sout_next  = r_sout;
      w_done_next  = 1'b0;
      w_cnt_next   = r_cnt;
      w_mode_next  = r_mode;

      if (ld) begin
         // Load wins over everything but clear and silently aborts a run.
         w_data_next  = data_in;
         w_state_next = IDLE;
         w_cnt_next   = '0;
      end else if (r_state == RUN) begin
         w_data_next = w_step_run[WIDTH-1:0];
         w_sout_next = w_step_run[WIDTH];
         w_cnt_next  = r_cnt - 1'b1;
         if (r_cnt == CNT_W'(1)) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
         end
      end else if (start) begin
         if (w_amt == '0) begin
            // Zero-length sequence completes immediately without touching data.
            w_done_next = 1'b1;
         end else begin
            w_state_next = RUN;
            w_cnt_next   = w_amt;
            w_mode_next  = mode;
         end
      end else if (shift_en) begin
         w_data_next = w_step_man[WIDTH-1:0];
         w_sout_next = w_step_man[WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_sout  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_mode  <= 2'b00;
      end else begin
         r_state <= w_state_next;
         r_data  <= w_data_next;
         r_sout  <= w_sout_next;
         r_done  <= w_done_next;
         r_cnt   <= w_cnt_next;
         r_mode  <= w_mode_next;
      end
   end

   assign data_out = r_data;
   assign s_out    = r_sout;
   assign busy     = (r_state == RUN);
   assign done     = r_done;

endmodule
